div_wave_gen: RTL and testbench



---
 rtl/div_wave_gen_if.sv | 22 ++
 rtl/div_wave_gen.sv | 95 +++++++++
 tb/tb_div_wave_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/div_wave_gen_if.sv
// Signal bundle between the frequency regulator and the PSI waveform generator.
// The regulator side drives the run request and ratio; the generator drives the waveform and status.
interface div_wave_gen_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             wave_out;
    logic             period_done;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] phase_cnt;

    modport master (
        output en, div_in,
        input  wave_out, period_done, active_div, phase_cnt
    );

    modport slave (
        input  en, div_in,
        output wave_out, period_done, active_div, phase_cnt
    );
endinterface

// File: rtl/div_wave_gen.sv
// 50 %-duty PSI generator: D cycles high, D cycles low, with the ratio latched only at period starts.
// All outputs come straight from registers, so there is no input-to-output combinational path.
module div_wave_gen #(
    parameter int               WIDTH     = 8,
    parameter int               MIN_DIV   = 2,
    parameter logic [WIDTH-1:0] RESET_DIV = 8'h7F
) (
    input  logic           clk,
    input  logic           rst,
    div_wave_gen_if.slave  bus
);
    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e           state_q;
    logic             wave_q;
    logic             done_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] cnt_q;

    logic [WIDTH-1:0] div_d;
    logic             phase_end;

    // Clamp the requested ratio and detect the last cycle of a phase.
    always_comb begin
        div_d     = (bus.div_in < MIN_DIV_W) ? MIN_DIV_W : bus.div_in;
        phase_end = (cnt_q == div_q - ONE);
    end

    // NOTE: every register in this block uses <= so all updates see the pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wave_q  <= 1'b0;
            done_q  <= 1'b0;
            div_q   <= RESET_DIV;
            cnt_q   <= '0;
        end else begin
            // NOTE: the boundary pulse defaults low here so it lasts exactly one cycle.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.en) begin
                        state_q <= HIGH;
                        wave_q  <= 1'b1;
                        div_q   <= div_d;
                        done_q  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        state_q <= LOW;
                        wave_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        cnt_q  <= '0;
                        done_q <= 1'b1;
                        if (bus.en) begin
                            state_q <= HIGH;
                            wave_q  <= 1'b1;
                            div_q   <= div_d;
                        end else begin
                            state_q <= IDLE;
                            wave_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wave_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.wave_out    = wave_q;
    assign bus.period_done = done_q;
    assign bus.active_div  = div_q;
    assign bus.phase_cnt   = cnt_q;
endmodule

// File: tb/tb_div_wave_gen.sv
// Scoreboard bench for div_wave_gen: a period-level reference model predicts every output cycle.
// Directed scenarios, random en/ratio traffic and a closed loop with a simple regulator.
`timescale 1ns/1ps
module tb_div_wave_gen;
    logic clk;
    logic rst;

    div_wave_gen_if #(.WIDTH(8)) bus ();

    div_wave_gen #(.WIDTH(8), .MIN_DIV(2), .RESET_DIV(8'h7F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       wave;
        logic       done;
        logic [7:0] div;
        logic [7:0] cnt;
    } exp_t;

    exp_t sched[$];
    exp_t exp_q[$];
    bit   busy;
    logic [7:0] last_div;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a whole period is scheduled at once from the clamped ratio.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sched.delete();
            exp_q.delete();
            busy     = 1'b0;
            last_div = 8'h7F;
        end else begin
            if (sched.size() == 0) begin
                if (bus.en) begin
                    int d;
                    d = (bus.div_in < 8'd2) ? 2 : int'(bus.div_in);
                    last_div = 8'(d);
                    for (int i = 0; i < d; i++) sched.push_back('{1'b1, i == 0, 8'(d), 8'(i)});
                    for (int i = 0; i < d; i++) sched.push_back('{1'b0, 1'b0, 8'(d), 8'(i)});
                    busy = 1'b1;
                end else begin
                    sched.push_back('{1'b0, busy, last_div, 8'd0});
                    busy = 1'b0;
                end
            end
            exp_q.push_back(sched.pop_front());
        end
    end

    // Monitor: compares one predicted cycle against the DUT mid-cycle.
    always @(negedge clk) begin
        if (rst && exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = '{bus.wave_out, bus.period_done, bus.active_div, bus.phase_cnt};
            check("scoreboard{wave,done,div,cnt}", 32'(a), 32'(e));
        end
    end

    task automatic cyc(input logic e, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.en     = e;
            bus.div_in = d;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wave"}, 32'(bus.wave_out), 32'd0);
        check({tag, "_done"}, 32'(bus.period_done), 32'd0);
        check({tag, "_cnt"},  32'(bus.phase_cnt), 32'd0);
        check({tag, "_div"},  32'(bus.active_div), 32'h7F);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int hi_cnt;
        int reg_div;
        logic prev_wave;

        rst        = 1'b0;
        bus.en     = 1'b1;
        bus.div_in = 8'd5;

        // Reset held with en high: outputs must stay at reset values.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        #2 rst = 1'b1;

        // Steady ratio 5.
        cyc(1'b1, 8'd5, 30);
        cyc(1'b0, 8'd5, 12);

        // Mid-period ratio change 4 -> 7 during the second high cycle.
        cyc(1'b1, 8'd4, 2);
        cyc(1'b1, 8'd7, 14);
        cyc(1'b0, 8'd7, 16);

        // Clamping of 0 and 1, then the widest ratio.
        cyc(1'b1, 8'd0, 6);
        cyc(1'b1, 8'd1, 6);
        cyc(1'b1, 8'd255, 4);
        cyc(1'b0, 8'd255, 520);

        // Graceful stop: drop en on the third high cycle, then restart with a fresh ratio.
        cyc(1'b1, 8'd6, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.wave_out && bus.phase_cnt == 8'd2 && bus.active_div == 8'd6) begin
                found  = 1'b1;
                bus.en = 1'b0;
            end
        end
        check("stop_reach_high2", 32'(found), 32'd1);
        cyc(1'b0, 8'd6, 20);
        cyc(1'b1, 8'd3, 8);
        cyc(1'b0, 8'd3, 10);

        // Random en and ratio traffic.
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, 8'($urandom_range(0, 12)), 1);
        cyc(1'b0, 8'd0, 30);

        // Async reset between edges in the LOW phase at phase_cnt 4.
        cyc(1'b1, 8'd9, 1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (!bus.wave_out && bus.phase_cnt == 8'd4 && bus.active_div == 8'd9) found = 1'b1;
        end
        check("async_reach_low4", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("async_reset_hold");
        #2 rst = 1'b1;
        cyc(1'b0, 8'd9, 3);

        // Closed loop with a halving-step regulator targeting 20.
        reg_div    = 127;
        hi_cnt     = 0;
        prev_wave  = 1'b0;
        found      = 1'b0;
        bus.en     = 1'b1;
        bus.div_in = 8'(reg_div);
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            if (bus.wave_out) begin
                hi_cnt++;
            end else if (prev_wave) begin
                int err;
                int step;
                err  = 20 - hi_cnt;
                step = err / 2;
                if (step == 0 && err != 0) step = (err > 0) ? 1 : -1;
                if (hi_cnt == 20) found = 1'b1;
                reg_div    = reg_div + step;
                bus.div_in = 8'(reg_div);
                hi_cnt     = 0;
            end
            prev_wave = bus.wave_out;
        end
        check("loop_converged", 32'(found), 32'd1);
        check("loop_active_div", 32'(bus.active_div), 32'd20);
        cyc(1'b0, 8'd20, 45);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
